beam_sample_serializer: RTL and testbench
=========================================

// Module: beam_sample_serializer
// PURPOSE
//   Stage downstream of the beamformer summer. Captures one frame of 40-bit summed samples
//   (a contiguous burst of in_valid) into an internal buffer. After the frame ends, streams it
//   as bytes, LSB first, to the UART transmitter over a valid/ready byte handshake.
//   Replaces ad-hoc RAM/UART sequencing with a single self-contained capture-and-drain stage.
// PARAMETERS
//   DATA_W     40    width of one summed sample
//   DEPTH      1024  sample words buffered per frame
//   BYTES      5     bytes per word, = ceil(DATA_W/8); upper pad bits are sent as 0
//   ADDR_W     10    buffer address width, = clog2(DEPTH)
// PORTS
//   clk        in   1       system clock; the only clock
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       sample strobe from the summer; high for every valid sample of a frame
//   in_data    in   DATA_W  summed sample; sampled when in_valid=1
//   tx_ready   in   1       UART can accept a byte this cycle
//   tx_valid   out  1       byte on tx_data is valid
//   tx_data    out  8       byte to transmit
//   busy       out  1       high in any state other than IDLE
//   frame_done out  1       one-cycle pulse after the last byte is accepted
//   overflow   out  1       sticky; set when a sample is dropped, cleared at the next frame start
// BEHAVIOUR
//   Reset (synchronous): state=IDLE, wr_ptr=rd_ptr=byte_idx=0, word_cnt=0.
//     All outputs are 0. Reset aborts any capture or drain, including mid-byte: tx_valid drops.
//   Handshake: a byte transfers on a rising clk when tx_valid && tx_ready.
//     While tx_valid=1 and no transfer has occurred, tx_data must not change.
//     tx_valid never deasserts without a transfer, except on reset.
//   FSM states:
//     IDLE:    in_valid=1 -> write in_data at addr 0, word_cnt=1, clear overflow -> CAPTURE.
//     CAPTURE: each cycle in_valid=1 writes a word. word_cnt saturates at DEPTH.
//              A word arriving with word_cnt==DEPTH is dropped and sets overflow.
//              in_valid=0 -> LOAD (HEADER if the header feature is compiled in).
//     LOAD:    issue a buffer read at rd_ptr (registered RAM, 1-cycle latency) -> SEND.
//     SEND:    the word read in LOAD is held in a shift register.
//              Present byte byte_idx = word[8*byte_idx +: 8] with tx_valid=1.
//              On each transfer, byte_idx++. After byte BYTES-1: byte_idx=0, rd_ptr++.
//              If rd_ptr==word_cnt -> DONE, else -> LOAD.
//              Throughput: one byte per cycle when tx_ready=1, plus one bubble per word for LOAD.
//     DONE:    frame_done=1 for one cycle, pointers cleared -> IDLE.
//   in_valid asserted in LOAD, SEND or DONE: sample is ignored and overflow sets.
//     The frame in flight is not disturbed.
//   Simultaneous in_valid=0 and a full buffer: go to drain normally; no drop.
//   Pointer arithmetic is modulo 2^ADDR_W. DEPTH must be a power of two.
// CONFIGURATION
//   SERIALIZER_HEADER_EN defined:
//     HEADER state emits 4 bytes before the data: 0xA5, 0x5A, word_cnt[7:0], word_cnt[15:8].
//     All 4 bytes use the same handshake. HEADER -> LOAD.
//   SERIALIZER_HEADER_EN undefined: no HEADER state; CAPTURE -> LOAD directly. Data only.
// STRUCTURE
//   beamformer_pkg holds:
//     - state encoding (IDLE, CAPTURE, HEADER, LOAD, SEND, DONE)
//     - SYNC0=8'hA5, SYNC1=8'h5A
//     - the DATA_W and BYTES defaults
//   Sub-module sample_buffer_ram: simple dual-port, one write port and one registered read port,
//     DEPTH x DATA_W, inferrable as block RAM. All sequencing stays in the top FSM.
// TESTING
//   1 Reset; 3-cycle burst 40'h0102030405, 40'h1112131415, 40'h2122232425; tx_ready=1:
//     15 bytes 05 04 03 02 01 15 14 ... 21, then frame_done pulses once.
//   2 Same frame with tx_ready toggled pseudo-randomly:
//     identical byte sequence, and tx_data stays stable while tx_valid=1 && tx_ready=0.
//   3 DEPTH+3 consecutive samples: exactly DEPTH*BYTES bytes out, overflow=1.
//     Start a new frame: overflow clears on its first sample.
//   4 in_valid pulsed during SEND: output stream unchanged, overflow=1.
//   5 Assert rst during byte 2 of word 1: next cycle tx_valid=0, busy=0.
//     A following 1-word frame drains correctly.
//   6 SERIALIZER_HEADER_EN, 2-word frame: A5 5A 02 00 then 10 data bytes.

Source files
------------

// File: rtl/beamformer_pkg.sv
// Shared definitions for the beamformer output path: serializer state encoding,
// header sync bytes and default sample geometry.
package beamformer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HEADER,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  localparam int DATA_W_DEF = 40;
  localparam int BYTES_DEF  = (DATA_W_DEF + 7) / 8;

endpackage

// File: rtl/sample_buffer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read data holds until the next read enable, so it doubles as the word holding register.
module sample_buffer_ram #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_p1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_p1 <= mem[rd_addr];
  end

endmodule

// File: rtl/beam_sample_serializer.sv
// Captures one burst of summed samples, then drains it LSB-first as bytes over valid/ready.
// Optional frame header (sync + word count) enabled by defining SERIALIZER_HEADER_EN.
module beam_sample_serializer
  import beamformer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1024,
  parameter int BYTES  = BYTES_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int IDX_W = $clog2((BYTES > 4) ? BYTES : 4);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, wr_addr;
  logic [ADDR_W:0]     word_cnt, rd_next;
  logic [IDX_W-1:0]    byte_idx;
  logic                overflow_q;
  logic                wr_en, rd_en, full, xfer, last_byte;
  logic [DATA_W-1:0]   rd_word_p1;
  logic [8*BYTES-1:0]  word_pad;

  function automatic logic [ADDR_W:0] cnt_sat_inc(input logic [ADDR_W:0] cnt);
    return (cnt == (ADDR_W+1)'(DEPTH)) ? cnt : cnt + 1'b1;
  endfunction

  sample_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (in_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_ptr),
    .rd_data_p1 (rd_word_p1)
  );

  assign full       = (word_cnt == (ADDR_W+1)'(DEPTH));
  assign wr_addr    = (state_q == IDLE) ? '0 : wr_ptr;
  assign rd_next    = {1'b0, rd_ptr} + 1'b1;
  assign word_pad   = (8*BYTES)'(rd_word_p1);
  assign xfer       = tx_valid && tx_ready;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign overflow   = overflow_q;

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    last_byte = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        wr_en   = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (in_valid) wr_en = !full;
`ifdef SERIALIZER_HEADER_EN
        else state_d = HEADER;
`else
        else state_d = LOAD;
`endif
      end
`ifdef SERIALIZER_HEADER_EN
      HEADER: begin
        tx_valid  = 1'b1;
        last_byte = (byte_idx == IDX_W'(3));
        case (byte_idx[1:0])
          2'd0:    tx_data = SYNC0;
          2'd1:    tx_data = SYNC1;
          2'd2:    tx_data = 16'(word_cnt) >> 0;
          default: tx_data = 8'(16'(word_cnt) >> 8);
        endcase
        if (xfer && last_byte) state_d = LOAD;
      end
`endif
      LOAD: begin
        rd_en   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        tx_valid  = 1'b1;
        tx_data   = word_pad[8*byte_idx +: 8];
        last_byte = (byte_idx == IDX_W'(BYTES-1));
        if (xfer && last_byte) state_d = (rd_next == word_cnt) ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          wr_ptr     <= ADDR_W'(1);
          word_cnt   <= (ADDR_W+1)'(1);
          overflow_q <= 1'b0;
        end
        CAPTURE: if (in_valid) begin
          if (full) overflow_q <= 1'b1;
          else begin
            wr_ptr   <= wr_ptr + 1'b1;
            word_cnt <= cnt_sat_inc(word_cnt);
          end
        end
        DONE: begin
          if (in_valid) overflow_q <= 1'b1;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          word_cnt <= '0;
          byte_idx <= '0;
        end
        default: begin
          // LOAD/HEADER/SEND: late samples are refused without touching the frame in flight
          if (in_valid) overflow_q <= 1'b1;
          if (xfer) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
          if (xfer && last_byte && state_q == SEND) rd_ptr <= rd_ptr + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beam_sample_serializer.sv
// Bench for beam_sample_serializer: directed and randomized frames checked against a
// byte-queue model of the frame format. Header expectations follow SERIALIZER_HEADER_EN.
module tb_beam_sample_serializer;

  localparam int DATA_W = 40;
  localparam int DEPTH  = 1024;
  localparam int BYTES  = 5;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              busy;
  logic              frame_done;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] frame_q[$];
  logic [7:0]        exp_q[$];

  always #5 clk = ~clk;

  beam_sample_serializer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BYTES  (BYTES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected byte stream: optional header, then each kept word LSB byte first.
  task automatic model_frame();
    int kept;
    kept = (frame_q.size() > DEPTH) ? DEPTH : frame_q.size();
    exp_q.delete();
`ifdef SERIALIZER_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(kept[7:0]);
    exp_q.push_back(kept[15:8]);
`endif
    for (int w = 0; w < kept; w++)
      for (int b = 0; b < BYTES; b++)
        exp_q.push_back(8'(frame_q[w] >> (8*b)));
  endtask

  task automatic rand_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(DATA_W'({$urandom, $urandom}));
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain(input string tag, input bit rnd, input int pulse_at, input int abort_at);
    int got = 0;
    int cyc = 0;
    int done = 0;
    bit hold = 1'b0;
    bit pulsed = 1'b0;
    logic [7:0] held = 8'h00;
    while (done == 0 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && got == abort_at && tx_valid) begin
        rst = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, " rst tx_valid"}, 64'(tx_valid), 64'(0));
        chk({tag, " rst busy"}, 64'(busy), 64'(0));
        chk({tag, " rst tx_data"}, 64'(tx_data), 64'(0));
        chk({tag, " rst overflow"}, 64'(overflow), 64'(0));
        tx_ready = 1'b0;
        return;
      end
      in_valid = 1'b0;
      if (pulse_at >= 0 && !pulsed && cyc >= pulse_at && tx_valid) begin
        in_valid = 1'b1;
        in_data  = DATA_W'({$urandom, $urandom});
        pulsed   = 1'b1;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        chk({tag, " hold valid"}, 64'(tx_valid), 64'(1));
        chk({tag, " hold data"}, 64'(tx_data), 64'(held));
      end
      if (frame_done) done = 1;
      else if (tx_valid && tx_ready) begin
        if (got < exp_q.size()) chk($sformatf("%s byte%0d", tag, got), 64'(tx_data), 64'(exp_q[got]));
        else chk({tag, " extra byte"}, 64'(got), 64'(exp_q.size()));
        got++;
      end
      hold = tx_valid && !tx_ready;
      held = tx_data;
    end
    in_valid = 1'b0;
    tx_ready = 1'b0;
    chk({tag, " frame_done seen"}, 64'(done), 64'(1));
    chk({tag, " byte count"}, 64'(got), 64'(exp_q.size()));
    @(negedge clk);
    chk({tag, " busy after"}, 64'(busy), 64'(0));
    chk({tag, " done single"}, 64'(frame_done), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset tx_valid", 64'(tx_valid), 64'(0));
    chk("reset tx_data", 64'(tx_data), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset frame_done", 64'(frame_done), 64'(0));
    chk("reset overflow", 64'(overflow), 64'(0));

    // Directed three-word frame, receiver always ready
    frame_q = '{40'h0102030405, 40'h1112131415, 40'h2122232425};
    model_frame();
    send_frame();
    chk("t1 busy capture", 64'(busy), 64'(1));
    drain("t1", 1'b0, -1, -1);
    chk("t1 overflow", 64'(overflow), 64'(0));

    // Same frame under random backpressure
    send_frame();
    drain("t2", 1'b1, -1, -1);

    // Random frames of random length
    for (int f = 0; f < 4; f++) begin
      rand_frame($urandom_range(1, 24));
      model_frame();
      send_frame();
      drain("rnd", 1'b1, -1, -1);
      chk("rnd overflow", 64'(overflow), 64'(0));
    end

    // Over-long burst: only DEPTH words survive, overflow sticks until next frame
    rand_frame(DEPTH + 3);
    model_frame();
    send_frame();
    drain("t3 full", 1'b0, -1, -1);
    chk("t3 overflow set", 64'(overflow), 64'(1));
    rand_frame(2);
    model_frame();
    send_frame();
    chk("t3 overflow clear", 64'(overflow), 64'(0));
    drain("t3 next", 1'b1, -1, -1);

    // Exactly DEPTH words: no drop
    rand_frame(DEPTH);
    model_frame();
    send_frame();
    drain("depth exact", 1'b0, -1, -1);
    chk("depth exact overflow", 64'(overflow), 64'(0));

    // Stray sample during drain
    rand_frame(4);
    model_frame();
    send_frame();
    drain("t4", 1'b1, 8, -1);
    chk("t4 overflow", 64'(overflow), 64'(1));

    // Reset in the middle of word 1, byte 2, then a one-word frame
    rand_frame(2);
    model_frame();
    send_frame();
`ifdef SERIALIZER_HEADER_EN
    drain("t5", 1'b0, -1, 4 + BYTES + 2);
`else
    drain("t5", 1'b0, -1, BYTES + 2);
`endif
    rand_frame(1);
    model_frame();
    send_frame();
    drain("t5 after", 1'b1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
